// File: rtl/multi_cycle_add_seq.sv
// multi_cycle_add_seq: WIDTH-bit adder that reuses one 8-bit carry-select slice, LSB chunk first (SUBTRACT_EN adds a sub port).
// Latency: out_valid rises WIDTH/8 clocks after the accepting edge; one op per WIDTH/8+2 clocks.
// Backpressure: result held in DONE until out_ready; in_ready is low everywhere except IDLE.

module add8_csel (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       carry
);
   logic [4:0] lo;
   logic [4:0] hi0;
   logic [4:0] hi1;

   // Upper nibble is computed for both carry-ins, then picked by the lower nibble's carry.
   assign lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
   assign hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
   assign hi1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;

   assign sum   = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
   assign carry = lo[4] ? hi1[4] : hi0[4];
endmodule

module multi_cycle_add_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SUBTRACT_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);
   localparam int NCHUNK = WIDTH / 8;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   generate
      if (WIDTH < 8 || (WIDTH % 8) != 0) begin : g_bad_width
         $error("multi_cycle_add_seq: WIDTH must be a multiple of 8 and >= 8");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, sum_q;
   logic             carry_q, carry_out_q;
   logic [IDX_W-1:0] idx_q;
   logic [7:0]       slice_a, slice_b, slice_sum;
   logic             slice_carry;
   logic             accept, last_chunk;
   logic [WIDTH-1:0] b_in;
   logic             c_in;

`ifdef SUBTRACT_EN
   // Two's-complement subtract: invert B and force the chunk-0 carry to 1.
   assign b_in = sub ? ~b : b;
   assign c_in = sub | cin;
`else
   assign b_in = b;
   assign c_in = cin;
`endif

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign sum        = sum_q;
   assign carry      = carry_out_q;
   assign accept     = in_valid & in_ready;
   assign last_chunk = (int'(idx_q) == NCHUNK - 1);

   always_comb begin
      slice_a = '0;
      slice_b = '0;
      for (int k = 0; k < NCHUNK; k++) begin
         if (int'(idx_q) == k) begin
            slice_a = a_q[8*k +: 8];
            slice_b = b_q[8*k +: 8];
         end
      end
   end

   add8_csel u_slice (
      .a     (slice_a),
      .b     (slice_b),
      .cin   (carry_q),
      .sum   (slice_sum),
      .carry (slice_carry)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)   state_d = RUN;
         RUN:     if (last_chunk) state_d = DONE;
         DONE:    if (out_ready)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         carry_out_q <= 1'b0;
         idx_q       <= '0;
      end else if (accept) begin
         a_q     <= a;
         b_q     <= b_in;
         carry_q <= c_in;
         idx_q   <= '0;
      end else if (state_q == RUN) begin
         for (int k = 0; k < NCHUNK; k++) begin
            if (int'(idx_q) == k) begin
               sum_q[8*k +: 8] <= slice_sum;
            end
         end
         carry_q <= slice_carry;
         idx_q   <= idx_q + 1'b1;
         if (last_chunk) begin
            carry_out_q <= slice_carry;
         end
      end
   end
endmodule

// File: tb/tb_multi_cycle_add_seq.sv
// Directed and randomized bench for multi_cycle_add_seq (WIDTH=32), checked against plain-arithmetic reference sums.
module tb_multi_cycle_add_seq;
   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             out_ready = 1'b0;
   logic             cin = 1'b0;
   logic             sub = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] sum;
   logic             carry;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   multi_cycle_add_seq #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef SUBTRACT_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry     (carry)
   );

   // {carry, sum} of the requested operation, straight from arithmetic.
   function automatic logic [WIDTH:0] ref_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c, input logic s);
      logic [WIDTH:0] r;
      if (s)
         r = {1'b0, x} + {1'b0, ~y} + 1;
      else
         r = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full transaction; hold = cycles to stall the result, early_rdy = out_ready high from the start.
   task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                         input logic tc, input logic ts, input int hold, input logic early_rdy);
      logic [WIDTH:0]   e;
      logic [WIDTH-1:0] held_sum;
      logic             held_carry;
      int               lat;
      e = ref_op(ta, tb, tc, ts);
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);
      a = ta; b = tb; cin = tc; sub = ts;
      in_valid = 1'b1;
      out_ready = early_rdy;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = $urandom; b = $urandom; cin = 1'($urandom);
`ifdef SUBTRACT_EN
      sub = 1'($urandom);
`endif
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (out_valid) break;
         chk("run_in_ready", in_ready, 0);
      end
      chk("latency", lat, 4);
      chk("sum", sum, e[WIDTH-1:0]);
      chk("carry", carry, e[WIDTH]);
      held_sum = sum;
      held_carry = carry;
      if (!early_rdy) begin
         for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_sum", sum, held_sum);
            chk("hold_carry", carry, held_carry);
         end
         out_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("consumed_valid", out_valid, 0);
      chk("consumed_in_ready", in_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [WIDTH:0] q[$];
      logic [WIDTH:0] e;
      int             last_acc;
      int             n_acc;
      int             n_out;

      // Reset state.
      #7;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_carry", carry, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors: wrap to zero, carry-in, stalled result, ripple across chunks.
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
      run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 3, 1'b0);
      run_op(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b1);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1, 1'b0);

      // Random operands.
      for (int i = 0; i < 12; i++) begin
         logic rs;
         rs = 1'b0;
`ifdef SUBTRACT_EN
         rs = 1'($urandom);
`endif
         run_op($urandom, $urandom, 1'($urandom), rs, $urandom_range(0, 2), 1'($urandom));
      end

      // Streaming: in_valid and out_ready held high, operands change every cycle.
      last_acc = -1; n_acc = 0; n_out = 0;
      sub = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 66; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("stream_spurious_out", 1, 0);
            end else begin
               e = q.pop_front();
               chk("stream_sum", sum, e[WIDTH-1:0]);
               chk("stream_carry", carry, e[WIDTH]);
               n_out++;
            end
         end
         a = $urandom; b = $urandom; cin = 1'($urandom);
         if (in_ready) begin
            q.push_back(ref_op(a, b, cin, 1'b0));
            if (last_acc >= 0) chk("stream_gap", cyc - last_acc, 6);
            last_acc = cyc;
            n_acc++;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid && q.size() > 0) begin
            e = q.pop_front();
            chk("stream_sum", sum, e[WIDTH-1:0]);
            chk("stream_carry", carry, e[WIDTH]);
            n_out++;
         end
      end
      out_ready = 1'b0;
      chk("stream_count", n_out, n_acc);
      chk("stream_min_ops", (n_acc >= 10), 1);

      // Asynchronous reset after two RUN cycles discards the partial result.
      @(negedge clk);
      a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_in_ready", in_ready, 1);
      chk("arst_sum", sum, 0);
      chk("arst_carry", carry, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 0, 1'b0);

`ifdef SUBTRACT_EN
      run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0, 1'b0);
      run_op(32'h0000_0009, 32'h0000_0002, 1'b1, 1'b1, 0, 1'b0);
      run_op(32'h0000_0009, 32'h0000_0002, 1'b1, 1'b0, 0, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
